cache_array_nway: RTL

- Parametrised N-way set-associative tag/data/state array; successor to the fixed 2-way, 4-set array.
- Adds the following over the fixed array:
  - internal tag compare and hit detection;
  - per-set true-LRU victim selection;
  - typed operations;
  - a flush walker that streams dirty lines to the writeback path over a valid/ready handshake.
- Sits between the cache controller FSM and the memory writeback buffer.

---
 rtl/cache_pkg.sv | 16 +
 rtl/cache_lru_age.sv | 35 +++
 rtl/cache_array_nway.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared op codes and flush walker state encodings for the N-way cache array.
package cache_pkg;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_FILL  = 2'd2;
  localparam logic [1:0] OP_INV   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } flush_state_t;

endpackage

// File: rtl/cache_lru_age.sv
// True-LRU age vector for one set: age 0 is most recent, WAYS-1 is the victim.
// Touch takes effect on the next edge; no backpressure.
module cache_lru_age #(
  parameter  int WAYS  = 2,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         touch_en,
  input  logic [WAY_W-1:0]             touch_way,
  output logic [WAYS-1:0][WAY_W-1:0]   ages,
  output logic [WAY_W-1:0]             oldest_way
);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) ages[w] <= WAY_W'(w);
    end else if (touch_en) begin
      // Only ways younger than the touched one age, so the vector stays a permutation.
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way)
          ages[w] <= '0;
        else if (ages[w] < ages[touch_way])
          ages[w] <= ages[w] + WAY_W'(1);
      end
    end
  end

  always_comb begin
    oldest_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (ages[w] == WAY_W'(WAYS - 1)) oldest_way = WAY_W'(w);
  end

endmodule

// File: rtl/cache_array_nway.sv
// N-way set-associative tag/data/state array with zero-latency lookup, true-LRU victim
// selection and a flush walker streaming dirty lines out over wb_valid/wb_ready.
module cache_array_nway
  import cache_pkg::*;
#(
  parameter  int WAYS   = 2,
  parameter  int SETS   = 4,
  parameter  int TAG_W  = 28,
  parameter  int DATA_W = 32,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WAY_W  = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [IDX_W-1:0]  req_index,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              fill_dirty,
  output logic              hit,
  output logic [WAY_W-1:0]  hit_way,
  output logic [DATA_W-1:0] rd_data,
  output logic [WAY_W-1:0]  victim_way,
  output logic              victim_valid,
  output logic              victim_dirty,
  output logic [TAG_W-1:0]  victim_tag,
  output logic [DATA_W-1:0] victim_data,
  input  logic              flush_start,
  output logic              flush_busy,
  output logic              flush_done,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [IDX_W-1:0]  wb_index,
  output logic [WAY_W-1:0]  wb_way,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [DATA_W-1:0] wb_data
);

  logic              valid_q [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];

  logic [WAYS-1:0][WAY_W-1:0] ages_all   [SETS];
  logic [WAY_W-1:0]           oldest_all [SETS];

  flush_state_t     state;
  logic [IDX_W-1:0] cur_set;
  logic [WAY_W-1:0] cur_way;
  logic             last_line;

  logic             op_fire;
  logic             do_touch;
  logic [WAY_W-1:0] touch_way;
  logic [SETS-1:0]  touch_en;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;

  assign op_ready = (state == ST_IDLE);
  assign op_fire  = op_valid && op_ready;

  // Descending scans so the lowest-index match / free way is the one left standing.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_index][w] && (tag_q[req_index][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_index][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim_way = inv_found ? inv_way : oldest_all[req_index];
  end

  assign rd_data      = hit ? data_q[req_index][hit_way] : '0;
  assign victim_valid = valid_q[req_index][victim_way];
  assign victim_dirty = dirty_q[req_index][victim_way];
  assign victim_tag   = tag_q[req_index][victim_way];
  assign victim_data  = data_q[req_index][victim_way];

  assign do_touch  = op_fire && ((op_code == OP_FILL) ||
                     (hit && ((op_code == OP_READ) || (op_code == OP_WRITE))));
  assign touch_way = (op_code == OP_FILL) ? victim_way : hit_way;

  for (genvar s = 0; s < SETS; s++) begin : g_lru
    logic [WAYS-1:0] seen;

    assign touch_en[s] = do_touch && (req_index == IDX_W'(s));

    cache_lru_age #(.WAYS(WAYS)) u_lru (
      .clk        (clk),
      .rst        (rst),
      .touch_en   (touch_en[s]),
      .touch_way  (touch_way),
      .ages       (ages_all[s]),
      .oldest_way (oldest_all[s])
    );

    always_comb begin
      seen = '0;
      for (int w = 0; w < WAYS; w++) seen[ages_all[s][w]] = 1'b1;
    end

    a_age_perm: assert property (@(posedge clk) disable iff (rst) (&seen));
  end

  assign last_line = (cur_set == IDX_W'(SETS - 1)) && (cur_way == WAY_W'(WAYS - 1));
  assign wb_index  = cur_set;
  assign wb_way    = cur_way;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          data_q[s][w]  <= '0;
        end
      end
      state      <= ST_IDLE;
      cur_set    <= '0;
      cur_way    <= '0;
      wb_valid   <= 1'b0;
      wb_tag     <= '0;
      wb_data    <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      if (op_fire) begin
        case (op_code)
          OP_WRITE: if (hit) begin
            data_q[req_index][hit_way]  <= wr_data;
            dirty_q[req_index][hit_way] <= 1'b1;
          end
          OP_FILL: begin
            valid_q[req_index][victim_way] <= 1'b1;
            tag_q[req_index][victim_way]   <= req_tag;
            data_q[req_index][victim_way]  <= wr_data;
            dirty_q[req_index][victim_way] <= fill_dirty;
          end
          OP_INV: if (hit) begin
            valid_q[req_index][hit_way] <= 1'b0;
            dirty_q[req_index][hit_way] <= 1'b0;
          end
          default: ;
        endcase
      end

      flush_done <= 1'b0;
      case (state)
        ST_IDLE: if (flush_start) begin
          state      <= ST_SCAN;
          cur_set    <= '0;
          cur_way    <= '0;
          flush_busy <= 1'b1;
        end
        ST_SCAN: begin
          if (valid_q[cur_set][cur_way] && dirty_q[cur_set][cur_way]) begin
            state    <= ST_WB;
            wb_valid <= 1'b1;
            wb_tag   <= tag_q[cur_set][cur_way];
            wb_data  <= data_q[cur_set][cur_way];
          end else if (last_line) begin
            state      <= ST_DONE;
            flush_done <= 1'b1;
          end else if (cur_way == WAY_W'(WAYS - 1)) begin
            cur_way <= '0;
            cur_set <= cur_set + IDX_W'(1);
          end else begin
            cur_way <= cur_way + WAY_W'(1);
          end
        end
        ST_WB: if (wb_ready) begin
          dirty_q[cur_set][cur_way] <= 1'b0;
          wb_valid <= 1'b0;
          if (last_line) begin
            state      <= ST_DONE;
            flush_done <= 1'b1;
          end else begin
            state <= ST_SCAN;
            if (cur_way == WAY_W'(WAYS - 1)) begin
              cur_way <= '0;
              cur_set <= cur_set + IDX_W'(1);
            end else begin
              cur_way <= cur_way + WAY_W'(1);
            end
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          flush_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
